noc_axis_pkt_injector: RTL and testbench

//  Endpoint-side AXI-Stream packet source driving a router's local input port (axis_in_* of the router).

---
 rtl/noc_axis_pkg.sv | 13 +
 rtl/noc_axis_skid_buf.sv | 37 +++
 rtl/noc_axis_pkt_injector.sv | 109 ++++++++++
 tb/tb_noc_axis_pkt_injector.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_axis_pkg.sv
// noc_axis_pkg: shared FSM state and default flit layout for the packet injector
package noc_axis_pkg;
  localparam int TDATA_W = 32;
  localparam int TID_W = 2;
  localparam int TDEST_W = 4;
  typedef enum logic {IDLE, STREAM} inj_state_e;
  typedef struct packed {
    logic [TDATA_W-1:0] data;
    logic last;
    logic [TID_W-1:0] id;
    logic [TDEST_W-1:0] dest;
  } flit_t;
endpackage

// File: rtl/noc_axis_skid_buf.sv
// noc_axis_skid_buf: 2-entry buffer with registered output and registered in_ready
// Ports: clk_usr, rst_n (async active-low); in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream (out_* driven straight from flops).
// in_ready only looks at the skid slot, so it never depends on out_ready combinationally.
module noc_axis_skid_buf
  import noc_axis_pkg::*;
#(
  parameter type T = flit_t
) (
  input  logic clk_usr,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  T skid;
  logic skid_valid, push;
  assign in_ready = !skid_valid;
  assign push = in_valid & in_ready;
  always_ff @(posedge clk_usr or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      skid <= '0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid <= skid_valid | push;
      out_data <= skid_valid ? skid : push ? in_data : out_data;
      skid_valid <= 1'b0;
    end else if (push) begin
      skid <= in_data;
      skid_valid <= 1'b1;
    end
endmodule

// File: rtl/noc_axis_pkt_injector.sv
// noc_axis_pkt_injector: turns one (dest,id,len) command plus payload words into an AXIS packet
// Ports: clk_usr, rst_n (async active-low)
//        cmd_valid/cmd_ready/cmd_dest/cmd_id/cmd_len : packet command, len = flits-1
//        pld_valid/pld_ready/pld_data                : payload word stream
//        axis_out_{tvalid,tready,tdata,tlast,tid,tdest} : to router local input port
//        stat_pkts/stat_flits/stat_stalls            : counters, only with NOC_PKT_STATS_EN
// Optional feature macro: NOC_PKT_STATS_EN (statistics counters and ports).
module noc_axis_pkt_injector
  import noc_axis_pkg::*;
#(
  parameter int TDATA_WIDTH = TDATA_W,
  parameter int TID_WIDTH   = TID_W,
  parameter int TDEST_WIDTH = TDEST_W,
  parameter int LEN_WIDTH   = 8
`ifdef NOC_PKT_STATS_EN
  , parameter int STATS_WIDTH = 32
`endif
) (
  input  logic                   clk_usr,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [TDEST_WIDTH-1:0] cmd_dest,
  input  logic [TID_WIDTH-1:0]   cmd_id,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
  input  logic                   pld_valid,
  output logic                   pld_ready,
  input  logic [TDATA_WIDTH-1:0] pld_data,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TID_WIDTH-1:0]   axis_out_tid,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest
`ifdef NOC_PKT_STATS_EN
  , output logic [STATS_WIDTH-1:0] stat_pkts
  , output logic [STATS_WIDTH-1:0] stat_flits
  , output logic [STATS_WIDTH-1:0] stat_stalls
`endif
);
  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic last;
    logic [TID_WIDTH-1:0] id;
    logic [TDEST_WIDTH-1:0] dest;
  } pflit_t;
  inj_state_e state;
  logic [TDEST_WIDTH-1:0] dest_q;
  logic [TID_WIDTH-1:0] id_q;
  logic [LEN_WIDTH-1:0] len_q, beat_cnt;
  logic buf_ready, pld_hs, last_beat, cmd_hs;
  pflit_t in_flit, out_flit;
  assign pld_ready = (state == STREAM) & buf_ready;
  assign pld_hs = pld_valid & pld_ready;
  assign cmd_hs = cmd_valid & cmd_ready;
  // equality compare lets len=all-ones run 2^LEN_WIDTH beats without wrapping
  assign last_beat = beat_cnt == len_q;
  assign in_flit = {pld_data, last_beat, id_q, dest_q};
  always_ff @(posedge clk_usr or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      dest_q <= '0;
      id_q <= '0;
      len_q <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      cmd_ready <= !cmd_hs;
      if (cmd_hs) begin
        state <= STREAM;
        dest_q <= cmd_dest;
        id_q <= cmd_id;
        len_q <= cmd_len;
        beat_cnt <= '0;
      end
    end else if (pld_hs) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      state <= last_beat ? IDLE : STREAM;
      cmd_ready <= last_beat;
    end
  noc_axis_skid_buf #(.T(pflit_t)) u_buf (
    .clk_usr  (clk_usr),
    .rst_n    (rst_n),
    .in_valid (pld_hs),
    .in_ready (buf_ready),
    .in_data  (in_flit),
    .out_valid(axis_out_tvalid),
    .out_ready(axis_out_tready),
    .out_data (out_flit)
  );
  assign axis_out_tdata = out_flit.data;
  assign axis_out_tlast = out_flit.last;
  assign axis_out_tid = out_flit.id;
  assign axis_out_tdest = out_flit.dest;
`ifdef NOC_PKT_STATS_EN
  logic out_hs;
  assign out_hs = axis_out_tvalid & axis_out_tready;
  always_ff @(posedge clk_usr or negedge rst_n)
    if (!rst_n) begin
      stat_pkts <= '0;
      stat_flits <= '0;
      stat_stalls <= '0;
    end else begin
      stat_pkts <= stat_pkts + STATS_WIDTH'(out_hs & axis_out_tlast);
      stat_flits <= stat_flits + STATS_WIDTH'(out_hs);
      stat_stalls <= stat_stalls + STATS_WIDTH'(axis_out_tvalid & !axis_out_tready);
    end
`endif
endmodule

// File: tb/tb_noc_axis_pkt_injector.sv
// tb_noc_axis_pkt_injector: randomized self-checking bench with a packet-level reference queue
module tb_noc_axis_pkt_injector;
  logic clk_usr = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, pld_valid = 1'b0, axis_out_tready = 1'b0;
  logic [3:0] cmd_dest = '0;
  logic [1:0] cmd_id = '0;
  logic [7:0] cmd_len = '0;
  logic [31:0] pld_data = '0;
  logic cmd_ready, pld_ready, axis_out_tvalid, axis_out_tlast;
  logic [31:0] axis_out_tdata;
  logic [1:0] axis_out_tid;
  logic [3:0] axis_out_tdest;
`ifdef NOC_PKT_STATS_EN
  logic [31:0] stat_pkts, stat_flits, stat_stalls;
`endif

  noc_axis_pkt_injector dut (
    .clk_usr(clk_usr), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest), .cmd_id(cmd_id), .cmd_len(cmd_len),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready), .axis_out_tdata(axis_out_tdata),
    .axis_out_tlast(axis_out_tlast), .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest)
`ifdef NOC_PKT_STATS_EN
    , .stat_pkts(stat_pkts), .stat_flits(stat_flits), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk_usr = ~clk_usr;

  typedef struct {
    logic [31:0] data;
    logic last;
    logic [1:0] id;
    logic [3:0] dest;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [31:0] words[$];
  int checks = 0, passed = 0, cyc = 0, flits_out = 0;
  logic sb_en = 1'b0, held = 1'b0, h_last;
  logic [31:0] h_data;
  logic [1:0] h_id;
  logic [3:0] h_dest;

  always @(posedge clk_usr) cyc <= cyc + 1;

  // scoreboard: every output handshake must match the head of the expected flit queue,
  // and a stalled flit must be presented unchanged on the following cycle
  always @(negedge clk_usr) begin
    if (sb_en && rst_n) begin
      if (held) begin
        checks++;
        if (axis_out_tvalid !== 1'b1 || axis_out_tdata !== h_data || axis_out_tlast !== h_last ||
            axis_out_tid !== h_id || axis_out_tdest !== h_dest)
          $display("FAIL stall_hold: got v=%b d=%h l=%b id=%0d dest=%0d, want v=1 d=%h l=%b id=%0d dest=%0d",
                   axis_out_tvalid, axis_out_tdata, axis_out_tlast, axis_out_tid, axis_out_tdest,
                   h_data, h_last, h_id, h_dest);
        else passed++;
      end
      if (axis_out_tvalid && axis_out_tready) begin
        checks++;
        flits_out++;
        if (exp_q.size() == 0)
          $display("FAIL unexpected_flit: got d=%h l=%b, want no flit", axis_out_tdata, axis_out_tlast);
        else begin
          e = exp_q.pop_front();
          if (axis_out_tdata !== e.data || axis_out_tlast !== e.last || axis_out_tid !== e.id ||
              axis_out_tdest !== e.dest)
            $display("FAIL flit: got d=%h l=%b id=%0d dest=%0d, want d=%h l=%b id=%0d dest=%0d",
                     axis_out_tdata, axis_out_tlast, axis_out_tid, axis_out_tdest, e.data, e.last, e.id, e.dest);
          else passed++;
        end
      end
      held = axis_out_tvalid && !axis_out_tready;
      h_data = axis_out_tdata;
      h_last = axis_out_tlast;
      h_id = axis_out_tid;
      h_dest = axis_out_tdest;
    end else held = 1'b0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish before 1ms");
    $fatal(1);
  end

  // Entered and left at #1 after a rising edge. Expected flits come from the words queue:
  // flit i = {words[i], last = (i == len), id, dest}.
  task automatic drive_pkt(input logic [3:0] d, input logic [1:0] id, input int len, input int gap_pct,
                           input int stall_pct, input int hold, input bit drain, output int cmd_wait,
                           output int lat, output bit rdy_after, output int hold_hs);
    int idx, guard, hs_cyc, tv_cyc;
    bit in_hold;
    exp_t t;
    idx = 0; guard = 0; hs_cyc = -1; tv_cyc = -1; hold_hs = 0; cmd_wait = 0;
    for (int i = 0; i <= len; i++) begin
      t.data = words[i]; t.last = (i == len); t.id = id; t.dest = d;
      exp_q.push_back(t);
    end
    cmd_valid = 1'b1; cmd_dest = d; cmd_id = id; cmd_len = 8'(len);
    @(negedge clk_usr);
    while (!cmd_ready && cmd_wait < 50) begin
      @(posedge clk_usr); #1;
      cmd_wait++;
      @(negedge clk_usr);
    end
    if (cmd_wait == 50) begin
      checks++;
      $display("FAIL cmd_timeout: got cmd_ready=0 for 50 cycles, want 1");
    end
    @(posedge clk_usr); #1;
    cmd_valid = 1'b0;
    while ((idx <= len || guard < hold) && guard < 4000) begin
      in_hold = guard < hold;
      pld_valid = (idx <= len) && (in_hold || $urandom_range(99) >= 32'(gap_pct));
      pld_data = (idx <= len) ? words[idx] : 32'h0;
      axis_out_tready = !in_hold && $urandom_range(99) >= 32'(stall_pct);
      @(negedge clk_usr);
      if (tv_cyc < 0 && hs_cyc >= 0 && axis_out_tvalid) tv_cyc = cyc;
      if (pld_valid && pld_ready) begin
        if (hs_cyc < 0) hs_cyc = cyc;
        if (in_hold) hold_hs++;
        idx++;
      end
      @(posedge clk_usr); #1;
      guard++;
    end
    if (guard == 4000) begin
      checks++;
      $display("FAIL pld_timeout: got %0d words accepted, want %0d", idx, len + 1);
    end
    pld_valid = 1'b0;
    rdy_after = cmd_ready;
    if (drain) begin
      guard = 0;
      while (exp_q.size() > 0 && guard < 500) begin
        axis_out_tready = $urandom_range(99) >= 32'(stall_pct);
        @(negedge clk_usr);
        if (tv_cyc < 0 && hs_cyc >= 0 && axis_out_tvalid) tv_cyc = cyc;
        @(posedge clk_usr); #1;
        guard++;
      end
      if (guard == 500) begin
        checks++;
        $display("FAIL drain_timeout: got %0d flits pending, want 0", exp_q.size());
      end
    end
    lat = tv_cyc - hs_cyc;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({cmd_ready, pld_ready, axis_out_tvalid, axis_out_tlast, axis_out_tdata, axis_out_tid, axis_out_tdest} !== '0)
      $display("FAIL reset_outputs: got cr=%b pr=%b v=%b d=%h, want all 0", cmd_ready, pld_ready, axis_out_tvalid, axis_out_tdata);
    else passed++;
    @(negedge clk_usr); rst_n = 1'b1;
    @(posedge clk_usr); #1;
    checks++;
    if (cmd_ready !== 1'b1 || axis_out_tvalid !== 1'b0 || pld_ready !== 1'b0)
      $display("FAIL after_reset: got cr=%b v=%b pr=%b, want cr=1 v=0 pr=0", cmd_ready, axis_out_tvalid, pld_ready);
    else passed++;
    // reset in the middle of a packet with two flits buffered
    cmd_valid = 1'b1; cmd_dest = 4'h3; cmd_id = 2'd2; cmd_len = 8'd5;
    @(posedge clk_usr); #1;
    cmd_valid = 1'b0; pld_valid = 1'b1; pld_data = 32'h1234_5678; axis_out_tready = 1'b0;
    @(posedge clk_usr); #1;
    @(posedge clk_usr); #1;
    checks++;
    if (axis_out_tvalid !== 1'b1)
      $display("FAIL midrun_fill: got tvalid=%b, want 1", axis_out_tvalid);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, pld_ready, axis_out_tvalid, axis_out_tlast, axis_out_tdata, axis_out_tid, axis_out_tdest} !== '0)
      $display("FAIL midrun_reset: got cr=%b pr=%b v=%b l=%b d=%h id=%0d dest=%0d, want all 0",
               cmd_ready, pld_ready, axis_out_tvalid, axis_out_tlast, axis_out_tdata, axis_out_tid, axis_out_tdest);
    else passed++;
`ifdef NOC_PKT_STATS_EN
    checks++;
    if ({stat_pkts, stat_flits, stat_stalls} !== '0)
      $display("FAIL reset_stats: got %0d/%0d/%0d, want 0/0/0", stat_pkts, stat_flits, stat_stalls);
    else passed++;
`endif
    pld_valid = 1'b0;
    @(negedge clk_usr); rst_n = 1'b1;
    @(posedge clk_usr); #1;
    checks++;
    if (cmd_ready !== 1'b1 || axis_out_tvalid !== 1'b0)
      $display("FAIL midrun_release: got cr=%b v=%b, want cr=1 v=0", cmd_ready, axis_out_tvalid);
    else passed++;
    exp_q.delete();
    sb_en = 1'b1;
  endtask

  task automatic test_basic();
    int w, lat, hh, f0;
    bit ra;
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back(32'hA0 + 32'(i));
    f0 = flits_out;
    drive_pkt(4'h5, 2'd1, 3, 0, 0, 0, 1'b1, w, lat, ra, hh);
    checks++;
    if (lat !== 1) $display("FAIL basic_latency: got %0d cycles, want 1", lat);
    else passed++;
    checks++;
    if (flits_out - f0 !== 4) $display("FAIL basic_count: got %0d flits, want 4", flits_out - f0);
    else passed++;
  endtask

  task automatic test_single();
    int w, lat, hh, f0;
    bit ra;
    words.delete();
    words.push_back(32'hDEAD);
    f0 = flits_out;
    drive_pkt(4'hA, 2'd3, 0, 0, 0, 0, 1'b1, w, lat, ra, hh);
    checks++;
    if (ra !== 1'b1) $display("FAIL single_cmd_ready: got %b, want 1", ra);
    else passed++;
    checks++;
    if (flits_out - f0 !== 1) $display("FAIL single_count: got %0d flits, want 1", flits_out - f0);
    else passed++;
  endtask

  task automatic test_random_stall();
    int w, lat, hh, f0;
    bit ra;
    for (int r = 0; r < 4; r++) begin
      words.delete();
      for (int i = 0; i < 8; i++) words.push_back($urandom);
      f0 = flits_out;
      drive_pkt(4'($urandom), 2'($urandom), 7, 30, 50, 0, 1'b1, w, lat, ra, hh);
      checks++;
      if (flits_out - f0 !== 8) $display("FAIL stall_count: got %0d flits, want 8", flits_out - f0);
      else passed++;
    end
  endtask

  task automatic test_long();
    int w, lat, hh, f0;
    bit ra;
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back($urandom);
    f0 = flits_out;
    drive_pkt(4'h9, 2'd0, 255, 10, 20, 8, 1'b1, w, lat, ra, hh);
    checks++;
    if (hh !== 2) $display("FAIL long_fill: got %0d words taken while tready=0, want 2", hh);
    else passed++;
    checks++;
    if (flits_out - f0 !== 256) $display("FAIL long_count: got %0d flits, want 256", flits_out - f0);
    else passed++;
    checks++;
    if (ra !== 1'b1) $display("FAIL long_cmd_ready: got %b, want 1", ra);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int w, lat, hh, f0, len1, len2;
    bit ra;
    len1 = int'($urandom_range(5, 1));
    len2 = int'($urandom_range(5, 0));
    f0 = flits_out;
    words.delete();
    for (int i = 0; i <= len1; i++) words.push_back($urandom);
    drive_pkt(4'h1, 2'd2, len1, 0, 0, 0, 1'b0, w, lat, ra, hh);
    checks++;
    if (ra !== 1'b1) $display("FAIL b2b_cmd_ready: got %b, want 1", ra);
    else passed++;
    words.delete();
    for (int i = 0; i <= len2; i++) words.push_back($urandom);
    drive_pkt(4'hE, 2'd1, len2, 0, 0, 0, 1'b1, w, lat, ra, hh);
    checks++;
    if (w !== 0) $display("FAIL b2b_cmd_wait: got %0d cycles, want 0", w);
    else passed++;
    checks++;
    if (flits_out - f0 !== len1 + len2 + 2)
      $display("FAIL b2b_count: got %0d flits, want %0d", flits_out - f0, len1 + len2 + 2);
    else passed++;
  endtask

`ifdef NOC_PKT_STATS_EN
  task automatic test_stats();
    int w, lat, hh;
    bit ra;
    rst_n = 1'b0;
    @(negedge clk_usr); rst_n = 1'b1;
    @(posedge clk_usr); #1;
    axis_out_tready = 1'b1;
    words.delete(); words.push_back(32'h11); words.push_back(32'h12);
    drive_pkt(4'h2, 2'd0, 1, 0, 0, 6, 1'b1, w, lat, ra, hh);
    words.delete(); words.push_back(32'h21);
    drive_pkt(4'h3, 2'd1, 0, 0, 0, 0, 1'b1, w, lat, ra, hh);
    words.delete(); words.push_back(32'h31); words.push_back(32'h32); words.push_back(32'h33);
    drive_pkt(4'h4, 2'd2, 2, 0, 0, 0, 1'b1, w, lat, ra, hh);
    checks++;
    if (stat_pkts !== 32'd3 || stat_flits !== 32'd6 || stat_stalls !== 32'd5)
      $display("FAIL stats: got pkts=%0d flits=%0d stalls=%0d, want 3/6/5", stat_pkts, stat_flits, stat_stalls);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_random_stall();
    test_long();
    test_back_to_back();
`ifdef NOC_PKT_STATS_EN
    test_stats();
`endif
    checks++;
    if (exp_q.size() != 0) $display("FAIL leftover: got %0d flits never emitted, want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
